// File: rtl/pat_slot_sched_pkg.sv
// Shared types and constants for the paddle-datapath slot scheduler.
package pat_slot_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ARB,
    S_FETCH,
    S_UPDATE,
    S_HALT
  } state_t;

  localparam int CODE_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 8;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

endpackage

// File: rtl/pat_slot_sched_rr_arb2.sv
// Two-way round-robin picker: on a tie the player that did not win last time is chosen.
module pat_slot_sched_rr_arb2
  import pat_slot_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = P0;
    case (req)
      2'b01:   gnt_idx = P0;
      2'b10:   gnt_idx = P1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = P0;
    endcase
  end

endmodule

// File: rtl/pat_slot_sched.sv
// Slot sequencer/arbiter for the shared paddle datapath: one code update per game tick.
// Optional stale-player watchdog with synthetic centred-paddle slots: define PAT_WATCHDOG_EN.
module pat_slot_sched
  import pat_slot_sched_pkg::*;
#(
  parameter int CODE_W  = CODE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              brk,
  input  logic [1:0]        code_vld,
  input  logic [CODE_W-1:0] code0,
  input  logic [CODE_W-1:0] code1,
  output logic [1:0]        code_rdy,
  output logic              dp_init,
  output logic              dp_fetch,
  output logic              dp_update,
  output logic              dp_sel,
  output logic [CODE_W-1:0] dp_code,
  input  logic              dp_clear,
  input  logic              dp_stall,
  output logic              halted,
  output logic [1:0]        stale
);

  state_t     state, state_nxt;
  logic       last_grant;
  logic       brk_pend, brk_pend_nxt;
  logic       grant_now;
  logic [1:0] req_eff;
  logic [1:0] stale_int;
  logic       gnt_vld, gnt_idx;

  pat_slot_sched_rr_arb2 u_arb (
    .req     (req_eff),
    .last    (last_grant),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // A break seen during FETCH is remembered so UPDATE always follows FETCH.
  always_comb begin
    state_nxt    = state;
    brk_pend_nxt = 1'b0;
    grant_now    = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_INIT;
      S_INIT: state_nxt = brk ? S_HALT : S_ARB;
      S_ARB: begin
        if (brk) begin
          state_nxt = S_HALT;
        end else if (dp_clear) begin
          state_nxt = S_INIT;
        end else if (tick && !dp_stall && gnt_vld) begin
          state_nxt = S_FETCH;
          grant_now = 1'b1;
        end
      end
      S_FETCH: begin
        state_nxt    = S_UPDATE;
        brk_pend_nxt = brk;
      end
      S_UPDATE: state_nxt = (brk || brk_pend) ? S_HALT : S_ARB;
      S_HALT:   if (start && !brk) state_nxt = S_INIT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      brk_pend   <= 1'b0;
      last_grant <= P1;
      code_rdy   <= '0;
      dp_init    <= 1'b0;
      dp_fetch   <= 1'b0;
      dp_update  <= 1'b0;
      dp_sel     <= P0;
      dp_code    <= '0;
      halted     <= 1'b0;
    end else begin
      state     <= state_nxt;
      brk_pend  <= brk_pend_nxt;
      dp_init   <= (state_nxt == S_INIT);
      dp_fetch  <= (state_nxt == S_FETCH);
      dp_update <= (state_nxt == S_UPDATE);
      halted    <= (state_nxt == S_HALT);
      code_rdy  <= '0;
      if (grant_now) begin
        last_grant <= gnt_idx;
        dp_sel     <= gnt_idx;
        // A grant to a player without valid data is a synthetic centred-paddle slot.
        if (code_vld[gnt_idx]) begin
          dp_code           <= gnt_idx ? code1 : code0;
          code_rdy[gnt_idx] <= 1'b1;
        end else begin
          dp_code <= '0;
        end
      end
    end
  end

`ifdef PAT_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) wd_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (state == S_INIT || (code_rdy[i] && code_vld[i])) begin
          wd_cnt[i] <= '0;
        end else if (tick && wd_cnt[i] != CW'(TIMEOUT)) begin
          wd_cnt[i] <= wd_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) stale_int[i] = (wd_cnt[i] == CW'(TIMEOUT));
  end

  assign req_eff = code_vld | stale_int;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign stale_int      = '0;
  assign req_eff        = code_vld;
`endif

  assign stale = stale_int;

endmodule
